mips_fetch_unit: RTL and testbench

//   Instruction-fetch initiator for the single-issue MIPS core; drives the word-indexed

---
 rtl/mips_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_mips_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction-fetch stage for the single-issue MIPS core. Holds the program
// counter, drives the word-indexed instruction ROM, and keeps a one-entry
// IF/ID register that is handed to decode with a valid/ready handshake.
// Branch/jump redirects from execute reload the PC and flush the IF/ID entry.
//
// Parameters
//   WIDTH     data/address width
//   RESET_PC  byte address of the first fetch after reset
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   o_imem_addr         word index presented to the ROM ({2'b00, pc[WIDTH-1:2]})
//   i_imem_rd           ROM read data, combinational from o_imem_addr
//   i_halt              stop starting new fetches; the IF/ID entry still drains
//   i_redirect_valid    taken branch/jump this cycle
//   i_redirect_pc       byte target of the redirect
//   o_id_valid          IF/ID entry holds a valid instruction
//   i_id_ready          decode accepts the entry this cycle
//   o_id_instr          fetched instruction
//   o_id_pc             byte address of o_id_instr
//   o_id_pc_plus4       o_id_pc + 4 (link value)
//   o_misalign_err      sticky flag, set by a redirect to a non-word address
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic [WIDTH-1:0] i_imem_rd,
    input  logic             i_halt,
    input  logic             i_redirect_valid,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic             o_id_valid,
    input  logic             i_id_ready,
    output logic [WIDTH-1:0] o_id_instr,
    output logic [WIDTH-1:0] o_id_pc,
    output logic [WIDTH-1:0] o_id_pc_plus4,
    output logic             o_misalign_err
);

    // PC reset value with the byte offset forced to zero so pc[1:0] is
    // always 00, even if RESET_PC is given with stray low bits.
    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};

    // Architectural state
    logic [WIDTH-1:0] r_pc;
    logic             r_id_valid;
    logic [WIDTH-1:0] r_id_instr;
    logic [WIDTH-1:0] r_id_pc;
    logic [WIDTH-1:0] r_id_pc_plus4;
    logic             r_misalign_err;

    // Handshake qualifiers and next-state values
    logic             w_take;
    logic             w_slot_free;
    logic             w_fetch;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_redirect_target;
    logic             w_redirect_misaligned;

    logic [WIDTH-1:0] w_pc_next;
    logic             w_id_valid_next;
    logic [WIDTH-1:0] w_id_instr_next;
    logic [WIDTH-1:0] w_id_pc_next;
    logic [WIDTH-1:0] w_id_pc_plus4_next;
    logic             w_misalign_err_next;

    // The ROM is word addressed, so only the word index of the PC leaves
    // this block; the two byte-offset bits are replaced by zeros at the top.
    assign o_imem_addr = {2'b00, r_pc[WIDTH-1:2]};

    // The IF/ID slot can accept a new instruction when it is empty or when
    // decode is emptying it this very cycle. A redirect suppresses the fetch
    // because the instruction at the current PC is on the wrong path.
    assign w_take                = r_id_valid & i_id_ready;
    assign w_slot_free           = ~r_id_valid | i_id_ready;
    assign w_fetch               = w_slot_free & ~i_halt & ~i_redirect_valid;

    // Wraps modulo 2^WIDTH with no error indication.
    assign w_pc_plus4            = r_pc + WIDTH'(4);

    // The low two bits of a redirect target are dropped for the PC, but a
    // non-zero offset is remembered in the sticky error flag.
    assign w_redirect_target     = {i_redirect_pc[WIDTH-1:2], 2'b00};
    assign w_redirect_misaligned = |i_redirect_pc[1:0];

    // Next-state selection. Redirect has priority over fetch; when neither
    // happens the entry only drops its valid bit if decode took it, so the
    // payload stays stable while decode stalls.
    always_comb begin
        w_pc_next           = r_pc;
        w_id_valid_next     = r_id_valid & ~w_take;
        w_id_instr_next     = r_id_instr;
        w_id_pc_next        = r_id_pc;
        w_id_pc_plus4_next  = r_id_pc_plus4;
        w_misalign_err_next = r_misalign_err;

        if (i_redirect_valid) begin
            w_pc_next           = w_redirect_target;
            w_id_valid_next     = 1'b0;
            w_misalign_err_next = r_misalign_err | w_redirect_misaligned;
        end else if (w_fetch) begin
            w_pc_next          = w_pc_plus4;
            w_id_valid_next    = 1'b1;
            w_id_instr_next    = i_imem_rd;
            w_id_pc_next       = r_pc;
            w_id_pc_plus4_next = w_pc_plus4;
        end
    end

    // State register. Reset returns everything to a NOP-filled, empty IF/ID
    // entry with the PC at the reset vector; the first fetch happens on the
    // first rising edge after rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC_ALIGNED;
            r_id_valid     <= 1'b0;
            r_id_instr     <= '0;
            r_id_pc        <= '0;
            r_id_pc_plus4  <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_pc           <= w_pc_next;
            r_id_valid     <= w_id_valid_next;
            r_id_instr     <= w_id_instr_next;
            r_id_pc        <= w_id_pc_next;
            r_id_pc_plus4  <= w_id_pc_plus4_next;
            r_misalign_err <= w_misalign_err_next;
        end
    end

    assign o_id_valid     = r_id_valid;
    assign o_id_instr     = r_id_instr;
    assign o_id_pc        = r_id_pc;
    assign o_id_pc_plus4  = r_id_pc_plus4;
    assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
//
// Directed bench for mips_fetch_unit: a table of per-cycle vectors for the
// basic stream/stall/redirect behaviour, plus hand-written sequences for
// sticky misalignment, halt/resume, PC wrap and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rd;
    logic             halt;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [WIDTH-1:0] id_instr;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_pc_plus4;
    logic             misalign_err;

    int checks;
    int errors;

    mips_fetch_unit #(
        .WIDTH   (WIDTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_imem_addr     (imem_addr),
        .i_imem_rd       (imem_rd),
        .i_halt          (halt),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_id_valid      (id_valid),
        .i_id_ready      (id_ready),
        .o_id_instr      (id_instr),
        .o_id_pc         (id_pc),
        .o_id_pc_plus4   (id_pc_plus4),
        .o_misalign_err  (misalign_err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents by word index: the two program words from the first
    // test, everything else a recognisable pattern derived from the index.
    function automatic logic [WIDTH-1:0] romWord(input logic [WIDTH-1:0] idx);
        if (idx == 32'd0)      return 32'h2008_0005;
        else if (idx == 32'd1) return 32'h2009_0003;
        else                   return 32'hAC00_0000 ^ idx;
    endfunction

    assign imem_rd = romWord(imem_addr);

    typedef struct {
        logic             halt;
        logic             redir;
        logic [WIDTH-1:0] redirPc;
        logic             ready;
        logic             expValid;
        logic [WIDTH-1:0] expPc;
        logic [WIDTH-1:0] expAddr;
        logic             expMis;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic compare(input string name, input logic [WIDTH-1:0] actual,
                           input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, and return 1 ns
    // later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic h, input logic rv,
                                 input logic [WIDTH-1:0] rpc, input logic rdy);
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    // Full output comparison against an expected IF/ID entry. The payload
    // fields hold while invalid, so they are checked in every cycle.
    task automatic checkOutput(input string tag, input logic expValid,
                               input logic [WIDTH-1:0] expPc,
                               input logic [WIDTH-1:0] expAddr,
                               input logic expMis);
        logic [WIDTH-1:0] expWord;
        expWord = expPc >> 2;
        compare({tag, ".valid"},    WIDTH'(id_valid),     WIDTH'(expValid));
        compare({tag, ".imemAddr"}, imem_addr,            expAddr);
        compare({tag, ".misalign"}, WIDTH'(misalign_err), WIDTH'(expMis));
        compare({tag, ".pc"},       id_pc,                expPc);
        compare({tag, ".pcPlus4"},  id_pc_plus4,          expPc + 32'd4);
        compare({tag, ".instr"},    id_instr,             romWord(expWord));
    endtask

    task automatic checkResetState(input string tag);
        compare({tag, ".valid"},    WIDTH'(id_valid),     '0);
        compare({tag, ".instr"},    id_instr,             '0);
        compare({tag, ".pc"},       id_pc,                '0);
        compare({tag, ".pcPlus4"},  id_pc_plus4,          '0);
        compare({tag, ".misalign"}, WIDTH'(misalign_err), '0);
        compare({tag, ".imemAddr"}, imem_addr,            '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            halt  redir rpc           rdy  expV expPc         expAddr       mis
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 32'h0000_0002, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 32'h0000_0003, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 32'h0000_0003, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 32'h0000_0003, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 32'h0000_0003, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 32'h0000_0004, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_000C, 32'h0000_0004, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0040, 32'h0000_0011, 1'b0};
        // redirect together with a take: old entry consumed, flush applies
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0042, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0010, 1'b1};

        // Reset
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Table-driven stream / stall / redirect
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].halt, vecs[i].redir, vecs[i].redirPc, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expAddr, vecs[i].expMis);
        end

        // Ten fetches from 0x40; the misalignment flag must stay set
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        checkOutput("stickyMis", 1'b1, 32'h0000_0064, 32'h0000_001A, 1'b1);

        // Halt with the entry being taken: valid falls, pc frozen at 0x68
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("halt1", 1'b0, 32'h0000_0064, 32'h0000_001A, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("halt2", 1'b0, 32'h0000_0064, 32'h0000_001A, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("resume", 1'b1, 32'h0000_0068, 32'h0000_001B, 1'b1);

        // Redirect while halted still loads the target and flushes
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b0);
        checkOutput("haltRedir", 1'b0, 32'h0000_0068, 32'h0000_0040, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("haltRedirFetch", 1'b1, 32'h0000_0100, 32'h0000_0041, 1'b1);

        // Wrap of the PC through the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("wrapRedir", 1'b0, 32'h0000_0100, 32'h3FFF_FFFF, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("wrapTop", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("wrapZero", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1);

        // Asynchronous reset pulse mid-stream, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("asyncReset");
        @(posedge clk);
        #1;
        checkResetState("resetHeld");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("restart0", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("restart1", 1'b1, 32'h0000_0004, 32'h0000_0002, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
